// File: rtl/msk_round_const_gen.sv
// msk_round_const_gen
// Masked SKINNY-128 round-constant generator. Holds the public 6-bit
// round-constant LFSR and round counter, steps them on a per-round handshake
// and presents the constant in share-interleaved form (bit i, share j at
// roundcst[i*d+j]).
// Optional feature: define MSK_RC_REFRESH_EN to load fresh mask shares from
// rnd on every start/advance; otherwise shares 1..d-1 are constant zero.
module msk_round_const_gen #(
    parameter int d      = 2,
    parameter int ROUNDS = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               adv,
    input  logic [6*(d-1)-1:0] rnd,
    output logic [6*d-1:0]     roundcst,
    output logic               valid,
    output logic [5:0]         round,
    output logic               last,
    output logic               done
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state;
    logic [5:0]             rc;
    logic [5:0]             rc_next;
    logic [6*(d-1)-1:0]     fresh;

    // Next LFSR value; the injected constant 1 keeps the register away from zero.
    assign rc_next = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};

`ifdef MSK_RC_REFRESH_EN
    // Mask shares come straight from the fresh randomness input.
    assign fresh = rnd;
`else
    logic unused_rnd;

    // Without refresh the mask shares are zero and rnd is left unconnected.
    assign fresh      = '0;
    assign unused_rnd = ^rnd;
`endif

    // Builds the share-interleaved constant: shares 1..d-1 are the masks and
    // share 0 absorbs them so the XOR of all shares of each bit is the bit.
    function automatic logic [6*d-1:0] encode(input logic [5:0] c,
                                              input logic [6*(d-1)-1:0] m);
        logic [6*d-1:0] r;
        logic           s;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            s = c[i];
            for (int j = 1; j < d; j++) begin
                r[i*d+j] = m[i*(d-1)+j-1];
                s        = s ^ m[i*(d-1)+j-1];
            end
            r[i*d] = s;
        end
        return r;
    endfunction

    // Sequencer: IDLE/RUN control with LFSR, round counter and all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rc       <= 6'h00;
            round    <= 6'd0;
            roundcst <= '0;
            valid    <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= RUN;
                rc       <= 6'h01;
                round    <= 6'd0;
                roundcst <= encode(6'h01, fresh);
                valid    <= 1'b1;
                last     <= (LAST_ROUND == 6'd0);
            end else if (state == RUN && adv) begin
                if (round == LAST_ROUND) begin
                    state    <= IDLE;
                    roundcst <= encode(rc, fresh);
                    valid    <= 1'b0;
                    last     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    rc       <= rc_next;
                    round    <= round + 6'd1;
                    roundcst <= encode(rc_next, fresh);
                    last     <= ((round + 6'd1) == LAST_ROUND);
                end
            end
        end
    end

endmodule

// File: tb/tb_msk_round_const_gen.sv
// tb_msk_round_const_gen
// Self-checking bench for msk_round_const_gen. Expected constants come from
// the published SKINNY 6-bit round-constant table; a round-level model tracks
// sequence position, done pulses and captured masks. Define MSK_RC_REFRESH_EN
// to build with d=3 and mask refresh enabled.
module tb_msk_round_const_gen;

`ifdef MSK_RC_REFRESH_EN
    localparam int D = 3;
`else
    localparam int D = 2;
`endif
    localparam int ROUNDS = 40;
    localparam int RW     = 6 * (D - 1);
    localparam int CW     = 6 * D;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          adv;
    logic [RW-1:0] rnd;
    logic [CW-1:0] roundcst;
    logic          valid;
    logic [5:0]    round;
    logic          last;
    logic          done;
    logic [CW+8:0] obs;

    int checks = 0;
    int errors = 0;

    // SKINNY round constants, rounds 0..61.
    logic [5:0] rc_table [0:61] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A,
        6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04, 6'h09, 6'h13,
        6'h26, 6'h0C, 6'h19, 6'h32, 6'h25, 6'h0A, 6'h15, 6'h2A, 6'h14, 6'h28,
        6'h10, 6'h20
    };

    // Reference model state
    bit            m_active = 1'b0;
    int            m_idx    = 0;
    logic [5:0]    m_rc     = '0;
    logic [RW-1:0] m_mask   = '0;
    bit            m_done   = 1'b0;

    msk_round_const_gen #(
        .d      (D),
        .ROUNDS (ROUNDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .adv      (adv),
        .rnd      (rnd),
        .roundcst (roundcst),
        .valid    (valid),
        .round    (round),
        .last     (last),
        .done     (done)
    );

    assign obs = {roundcst, valid, round, last, done};

    // Free-running clock
    always #5 clk = ~clk;

    // Expected output vector from the model: masks in shares 1..D-1, share 0
    // chosen so every bit's shares XOR to the public constant bit.
    function automatic logic [CW+8:0] model_vec();
        logic [CW-1:0] c;
        logic          acc;
        c = '0;
        for (int i = 0; i < 6; i++) begin
            acc = 1'b0;
            for (int j = 1; j < D; j++) begin
                c[i*D+j] = m_mask[i*(D-1)+j-1];
                acc      = acc ^ m_mask[i*(D-1)+j-1];
            end
            c[i*D] = m_rc[i] ^ acc;
        end
        return {c, m_active, 6'(m_idx), (m_active && m_idx == ROUNDS - 1), m_done};
    endfunction

    // Recombines the shares of each bit of an observed masked constant.
    function automatic logic [5:0] unmask(input logic [CW-1:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < D; j++)
                r[i] = r[i] ^ v[i*D+j];
        return r;
    endfunction

    // Drives one cycle of inputs, advances the model across the edge and
    // returns at the following falling edge for sampling.
    task automatic tick(input logic s, input logic a, input logic r);
        rst_n = r;
        start = s;
        adv   = a;
        rnd   = RW'($urandom);
        @(posedge clk);
        m_done = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_idx    = 0;
            m_rc     = '0;
            m_mask   = '0;
        end else if (s) begin
            m_active = 1'b1;
            m_idx    = 0;
            m_rc     = rc_table[0];
`ifdef MSK_RC_REFRESH_EN
            m_mask   = rnd;
`endif
        end else if (m_active && a) begin
`ifdef MSK_RC_REFRESH_EN
            m_mask = rnd;
`endif
            if (m_idx == ROUNDS - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end else begin
                m_idx = m_idx + 1;
                m_rc  = rc_table[m_idx];
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (roundcst !== '0 || valid !== 1'b0 || done !== 1'b0 || last !== 1'b0 || round !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_values got cst=%h v=%b r=%0d l=%b d=%b expected all zero",
                     roundcst, valid, round, last, done);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL idle_adv[%0d] got %h expected %h", k, obs, model_vec());
            end
        end
    endtask

    task automatic test_full_sequence();
        int done_count = 0;
        tick(1'b1, 1'b0, 1'b1);
`ifndef MSK_RC_REFRESH_EN
        checks++;
        if (roundcst !== 12'h001) begin
            errors++;
            $display("[TB] FAIL round0_cst got %h expected 001", roundcst);
        end
`endif
        for (int k = 0; k < ROUNDS; k++) begin
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL full_seq[%0d] got %h expected %h", k, obs, model_vec());
            end
            checks++;
            if (unmask(roundcst) !== rc_table[k] || round !== 6'(k) || last !== (k == ROUNDS - 1)) begin
                errors++;
                $display("[TB] FAIL full_const[%0d] got rc=%h r=%0d l=%b expected rc=%h r=%0d l=%b",
                         k, unmask(roundcst), round, last, rc_table[k], k, (k == ROUNDS - 1));
            end
            tick(1'b0, 1'b1, 1'b1);
            if (done === 1'b1) done_count++;
        end
        checks++;
        if (valid !== 1'b0 || last !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL end_of_seq got v=%b l=%b d=%b expected v=0 l=0 d=1", valid, last, done);
        end
        tick(1'b0, 1'b0, 1'b1);
        if (done === 1'b1) done_count++;
        checks++;
        if (done_count !== 1) begin
            errors++;
            $display("[TB] FAIL done_pulses got %0d expected 1", done_count);
        end
    endtask

    task automatic test_stall();
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            for (int h = 0; h < 2; h++) begin
                tick(1'b0, 1'b0, 1'b1);
                checks++;
                if (obs !== model_vec() || unmask(roundcst) !== rc_table[k] || round !== 6'(k)) begin
                    errors++;
                    $display("[TB] FAIL stall_hold[%0d] got %h expected %h const %h",
                             k, obs, model_vec(), rc_table[k]);
                end
            end
            tick(1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL stall_adv[%0d] got %h expected %h", k, obs, model_vec());
            end
        end
    endtask

    task automatic test_restart_priority();
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (round !== 6'd5) begin
            errors++;
            $display("[TB] FAIL pre_restart_round got %0d expected 5", round);
        end
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (round !== 6'd0 || unmask(roundcst) !== 6'h01 || done !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_priority got r=%0d rc=%h d=%b v=%b expected r=0 rc=01 d=0 v=1",
                     round, unmask(roundcst), done, valid);
        end
    endtask

    task automatic test_reset_mid_run();
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset got %h expected 0", obs);
        end
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_nodone got d=%b v=%b expected 0 0", done, valid);
        end
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (unmask(roundcst) !== 6'h01 || round !== 6'd0 || valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resume_after_reset got rc=%h r=%0d v=%b expected 01 0 1",
                     unmask(roundcst), round, valid);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < ROUNDS; k++) tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_done got %b expected 1", done);
        end
        tick(1'b1, 1'b0, 1'b1);
        checks++;
        if (obs !== model_vec() || valid !== 1'b1 || round !== 6'd0) begin
            errors++;
            $display("[TB] FAIL b2b_restart got %h expected %h", obs, model_vec());
        end
    endtask

`ifdef MSK_RC_REFRESH_EN
    task automatic test_refresh();
        logic [CW-1:0] prev;
        logic          accepted;
        tick(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 150; k++) begin
            prev     = roundcst;
            accepted = valid && ($urandom_range(0, 1) == 1);
            tick(1'b0, accepted, 1'b1);
            checks++;
            if (obs !== model_vec() || unmask(roundcst) !== m_rc) begin
                errors++;
                $display("[TB] FAIL refresh_xor[%0d] got %h expected %h", k, obs, model_vec());
            end
            checks++;
            if (accepted) begin
                for (int i = 0; i < 6; i++)
                    for (int j = 1; j < D; j++)
                        if (roundcst[i*D+j] !== rnd[i*(D-1)+j-1]) begin
                            errors++;
                            $display("[TB] FAIL refresh_share[%0d] bit %0d share %0d got %b expected %b",
                                     k, i, j, roundcst[i*D+j], rnd[i*(D-1)+j-1]);
                        end
            end else if (roundcst !== prev) begin
                errors++;
                $display("[TB] FAIL refresh_hold[%0d] got %h expected %h", k, roundcst, prev);
            end
            if (!valid) tick(1'b1, 1'b0, 1'b1);
        end
    endtask
`endif

    task automatic test_random();
        logic s, a, r;
        for (int k = 0; k < 400; k++) begin
            s = ($urandom_range(0, 15) == 0);
            a = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 63) != 0);
            tick(s, a, r);
            checks++;
            if (obs !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random[%0d] got %h expected %h", k, obs, model_vec());
            end
        end
    endtask

    // Test sequence
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        adv   = 1'b0;
        rnd   = '0;
        test_reset();
        test_full_sequence();
        test_stall();
        test_restart_priority();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MSK_RC_REFRESH_EN
        test_refresh();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
